// File: rtl/and_pair_pkg.sv
// Shared types and helpers for the AND-pair collector.
// Holds the collector state encoding and the ones-count width helper.
package and_pair_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    function automatic int unsigned ones_width(input int unsigned win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/and_pair_popcount.sv
// Ones counter for a WIN-bit word.
// The result width is sized so that an all-ones word reports WIN exactly.
module and_pair_popcount
    import and_pair_pkg::*;
#(
    parameter int unsigned WIN = 8
) (
    input  logic [WIN-1:0]               word_i,
    output logic [ones_width(WIN)-1:0]   ones_o
);

    localparam int unsigned OW = ones_width(WIN);

    always_comb begin
        ones_o = '0;
        for (int i = 0; i < int'(WIN); i++) begin
            ones_o = ones_o + OW'(word_i[i]);
        end
    end

endmodule

// File: rtl/and_pair_collector.sv
// Collects q0 samples from the AND-pair stage into WIN-bit words, checks q0/q1 agreement
// and delivers word + ones-count over valid/ready. Optional counter: PAIR_ERR_CNT_EN.
//
// state   | meaning
// COLLECT | accepting samples into the collect register
// FULL    | a complete word waits for the output slot; new samples are dropped
module and_pair_collector
    import and_pair_pkg::*;
#(
    parameter int unsigned WIN   = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         q0,
    input  logic                         q1,
    input  logic                         clr_err,
    output logic [WIN-1:0]               out_data,
    output logic [ones_width(WIN)-1:0]   out_ones,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_mismatch,
    output logic                         overflow
`ifdef PAIR_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]             err_cnt
`endif
);

    localparam int unsigned OW    = ones_width(WIN);
    localparam int unsigned IDX_W = $clog2(WIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIN-1:0]    collect_q, collect_d;
    logic [WIN-1:0]    out_data_q, out_data_d;
    logic [OW-1:0]     out_ones_q, out_ones_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic              slot_free;
    logic              load;
    logic              accept;
    logic              drop;
    logic              mismatch;
    logic [WIN-1:0]    load_word;
    logic [OW-1:0]     load_ones;

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        collect_d = collect_q;
        load      = 1'b0;
        load_word = collect_q;
        accept    = 1'b0;
        drop      = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    accept           = 1'b1;
                    collect_d[idx_q] = q0;
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        load_word = collect_d;
                        if (slot_free) begin
                            load      = 1'b1;
                            collect_d = '0;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = collect_q;
                    state_d   = COLLECT;
                    collect_d = '0;
                    idx_d     = '0;
                    // The slot opens this cycle, so a concurrent sample starts the next word.
                    if (in_valid) begin
                        accept       = 1'b1;
                        collect_d[0] = q0;
                        idx_d        = IDX_W'(1);
                    end
                end else if (in_valid) begin
                    drop = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    and_pair_popcount #(.WIN(WIN)) u_popcount (
        .word_i (load_word),
        .ones_o (load_ones)
    );

    always_comb begin
        out_data_d  = out_data_q;
        out_ones_d  = out_ones_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = load_word;
            out_ones_d  = load_ones;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign mismatch = accept && (q0 != q1);

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        err_d = err_q;
        ovf_d = ovf_q;
        if (clr_err) begin
            err_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (mismatch) err_d = 1'b1;
        if (drop)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            collect_q   <= '0;
            out_data_q  <= '0;
            out_ones_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            collect_q   <= collect_d;
            out_data_q  <= out_data_d;
            out_ones_q  <= out_ones_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_ones     = out_ones_q;
    assign out_valid    = out_valid_q;
    assign err_mismatch = err_q;
    assign overflow     = ovf_q;

`ifdef PAIR_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_err) begin
            cnt_d = mismatch ? CNT_W'(1) : '0;
        end else if (mismatch && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_and_pair_collector.sv
// Self-checking bench for and_pair_collector: directed scenarios plus random traffic
// compared against a queue-based model of the collector's behaviour.
module tb_and_pair_collector;

    localparam int WIN   = 8;
    localparam int CNT_W = 4;
    localparam int OW    = $clog2(WIN + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            q0;
    logic            q1;
    logic            clr_err;
    logic [WIN-1:0]  out_data;
    logic [OW-1:0]   out_ones;
    logic            out_valid;
    logic            out_ready;
    logic            err_mismatch;
    logic            overflow;
`ifdef PAIR_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    and_pair_collector #(.WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .q0           (q0),
        .q1           (q1),
        .clr_err      (clr_err),
        .out_data     (out_data),
        .out_ones     (out_ones),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_mismatch (err_mismatch),
        .overflow     (overflow)
`ifdef PAIR_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending sample bits as a queue, at most one parked word.
    bit              m_part[$];
    bit              m_has_held;
    logic [WIN-1:0]  m_held;
    int              m_held_ones;
    logic [WIN-1:0]  m_data;
    int              m_ones;
    bit              m_valid;
    bit              m_err;
    bit              m_ovf;
    int              m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        m_has_held  = 0;
        m_held      = '0;
        m_held_ones = 0;
        m_data      = '0;
        m_ones      = 0;
        m_valid     = 0;
        m_err       = 0;
        m_ovf       = 0;
        m_cnt       = 0;
    endtask

    task automatic model_step(input bit iv, input bit a, input bit b, input bit rdy, input bit clr);
        bit             sf;
        bit             was_full;
        bit             ld;
        bit             acc;
        bit             drp;
        bit             mis;
        logic [WIN-1:0] lw;
        int             lo;
        sf       = !m_valid || rdy;
        was_full = m_has_held;
        ld  = 0;
        acc = 0;
        drp = 0;
        lw  = '0;
        lo  = 0;
        if (iv) begin
            if (was_full && !sf) drp = 1;
            else acc = 1;
        end
        if (was_full && sf) begin
            ld = 1;
            lw = m_held;
            lo = m_held_ones;
            m_has_held = 0;
        end
        if (acc) begin
            m_part.push_back(a);
            if (m_part.size() == WIN) begin
                logic [WIN-1:0] w;
                int n;
                w = '0;
                n = 0;
                foreach (m_part[i]) begin
                    if (m_part[i]) begin
                        w = w | (WIN'(1) << i);
                        n++;
                    end
                end
                m_part.delete();
                if (!was_full && sf) begin
                    ld = 1;
                    lw = w;
                    lo = n;
                end else begin
                    m_has_held  = 1;
                    m_held      = w;
                    m_held_ones = n;
                end
            end
        end
        if (ld) begin
            m_data  = lw;
            m_ones  = lo;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        mis = acc && (a != b);
        if (mis) m_err = 1;
        else if (clr) m_err = 0;
        if (drp) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (clr) m_cnt = mis ? 1 : 0;
        else if (mis && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    endtask

    task automatic step(input bit iv, input bit a, input bit b, input bit rdy, input bit clr,
                        input bit r = 1'b0);
        rst       = r;
        in_valid  = iv;
        q0        = a;
        q1        = b;
        out_ready = rdy;
        clr_err   = clr;
        @(posedge clk);
        if (r) model_reset();
        else model_step(iv, a, b, rdy, clr);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ones", 32'(out_ones), 32'(m_ones));
        check("err_mismatch", 32'(err_mismatch), 32'(m_err));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef PAIR_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic feed_word(input logic [WIN-1:0] w, input bit rdy);
        for (int i = 0; i < WIN; i++) step(1, w[i], w[i], rdy, 0);
    endtask

    initial begin
        logic [WIN-1:0] w1;
        logic [WIN-1:0] w2;
        int words;
        bit iv, a, b, rdy, clr, r;

        model_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);

        // 1: pattern 1,0,1,1,0,0,0,1 first sample in bit 0
        w1 = 8'b1000_1101;
        feed_word(w1, 1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h8D);
        check("t1_ones", 32'(out_ones), 32'd4);
        check("t1_err", 32'(err_mismatch), 32'd0);
        step(0, 0, 0, 1, 0);
        check("t1_drain", 32'(out_valid), 32'd0);

        // 2: stalled sink, second word parks, three samples lost
        step(0, 0, 0, 0, 0, 1);
        w1 = 8'h3C;
        w2 = 8'hA7;
        feed_word(w1, 0);
        feed_word(w2, 0);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_held", 32'(out_data), 32'h3C);
        step(0, 0, 0, 1, 0);
        check("t2_b2b_valid", 32'(out_valid), 32'd1);
        check("t2_b2b_data", 32'(out_data), 32'hA7);
        step(0, 0, 0, 1, 0);
        feed_word(8'h51, 1);
        check("t2_fresh", 32'(out_data), 32'h51);
        step(0, 0, 0, 1, 1);
        check("t2_clr", 32'(overflow), 32'd0);

        // 3: continuous stream, one word per WIN cycles
        step(0, 0, 0, 1, 0, 1);
        words = 0;
        for (int i = 0; i < 4 * WIN; i++) begin
            step(1, i[0] ^ i[2], i[0] ^ i[2], 1, 0);
            if (out_valid) words++;
        end
        check("t3_words", 32'(words), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd0);

        // 4: sticky mismatch and clear priority
        step(0, 0, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0);
        check("t4_set", 32'(err_mismatch), 32'd1);
        step(0, 0, 0, 1, 1);
        check("t4_clr", 32'(err_mismatch), 32'd0);
        step(1, 0, 1, 1, 1);
        check("t4_set_wins", 32'(err_mismatch), 32'd1);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 0);
`ifdef PAIR_ERR_CNT_EN
        check("t4_sat", 32'(err_cnt), 32'((2 ** CNT_W) - 1));
`endif

        // 5: reset mid-word discards the partial word
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        check("t5_rst_err", 32'(err_mismatch), 32'd0);
        feed_word(8'h96, 1);
        check("t5_word", 32'(out_data), 32'h96);

        // 6: popcount extremes
        feed_word(8'hFF, 1);
        check("t6_ff", 32'(out_data), 32'hFF);
        check("t6_ones8", 32'(out_ones), 32'd8);
        feed_word(8'h00, 1);
        check("t6_ones0", 32'(out_ones), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            iv  = ($urandom_range(0, 99) < 70);
            a   = 1'($urandom);
            b   = ($urandom_range(0, 99) < 6) ? !a : a;
            rdy = ($urandom_range(0, 99) < 55);
            clr = ($urandom_range(0, 99) < 3);
            r   = ($urandom_range(0, 999) < 5);
            step(iv, a, b, rdy, clr, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
